// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async_fifo write port among NUM_REQ producers.
// Optional FIFO_WR_ARB_STATS_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 24,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      w_enable,
  output logic [DATA_W-1:0]         w_data,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [15:0]               stall_cnt,
`endif
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int OWN_W = $clog2(NUM_REQ);
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_BURST = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [OWN_W-1:0] OWN_LAST = OWN_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OWN_W-1:0]   last_owner_q, last_owner_d;
  logic [OWN_W-1:0]   owner_q, owner_d;

  logic               pick_found_s;
  logic [OWN_W-1:0]   pick_idx_s;
  logic               owner_valid_s;
  logic               beat_s;
  logic [DATA_W-1:0]  data_arr_s [NUM_REQ];

  // Round-robin search; descending scan so the nearest index after last_owner wins
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      logic [OWN_W-1:0] idx_v;
      idx_v = OWN_W'((int'(last_owner_q) + i) % NUM_REQ);
      if (req_valid[idx_v]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = idx_v;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Unpack the flat requester data bus
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr_s[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign owner_valid_s = req_valid[owner_q];
  assign beat_s        = (state_q == ST_BURST) & owner_valid_s & ~fifo_full;

  // Burst FSM next-state
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d    = ST_BURST;
          owner_d    = pick_idx_s;
          grant_d    = ONE_HOT0 << pick_idx_s;
          beat_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (!owner_valid_s) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
        end else if (beat_s && (beat_cnt_q == CNT_LAST)) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
          beat_cnt_d   = '0;
        end else if (beat_s) begin
          beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          // fifo_full stall: everything frozen, owner keeps the port
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        grant_d      = '0;
        beat_cnt_d   = '0;
        last_owner_d = OWN_LAST;
      end
    endcase
  end

  // FSM and arbitration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      beat_cnt_q   <= '0;
      last_owner_q <= OWN_LAST;
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == ST_BURST);
  assign w_enable  = beat_s;
  assign req_ready = beat_s ? grant_q : '0;
  assign w_data    = beat_s ? data_arr_s[owner_q] : '0;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the owner was blocked by fifo_full
  always_comb begin
    if (busy && owner_valid_s && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter with a transaction-level reference model.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 24;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     grant;
  logic              fifo_full;
  logic              w_enable;
  logic [DW-1:0]     w_data;
  logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .fifo_full(fifo_full),
    .w_enable(w_enable), .w_data(w_data),
`ifdef FIFO_WR_ARB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] grant;
    logic          busy;
    logic [NR-1:0] ready;
  } cyc_t;

  cyc_t          cyc_q[$];
  logic [DW-1:0] wr_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: owner index (-1 = arbitrating), beats done in current grant
  int m_owner = -1;
  int m_last  = NR - 1;
  int m_done  = 0;
  int m_stall = 0;
  int seq [NR];
  bit held [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] tag(input int r, input int s);
    logic [7:0]  r8;
    logic [15:0] s16;
    r8  = 8'(r);
    s16 = 16'(s);
    return {r8, s16};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_done  = 0;
    m_stall = 0;
    for (int i = 0; i < NR; i++) held[i] = 1'b0;
  endtask

  // One cycle of the rules: arbitrate when idle, else beat / stall / release
  task automatic model_step();
    cyc_t e;
    bit   found;
    int   c;
    e.grant = (m_owner < 0) ? '0 : NR'(1 << m_owner);
    e.busy  = (m_owner >= 0);
    e.ready = '0;
    for (int i = 0; i < NR; i++) held[i] = req_valid[i];
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (!found && req_valid[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_done  = 0;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (fifo_full) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      e.ready = NR'(1 << m_owner);
      wr_q.push_back(tag(m_owner, seq[m_owner]));
      seq[m_owner]++;
      held[m_owner] = 1'b0;
      m_done++;
      if (m_done == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    cyc_q.push_back(e);
  endtask

  // Producers hold an un-accepted beat unless they randomly drop it
  task automatic drive(input logic [NR-1:0] mask, input int pv, input int pf, input int pd);
    logic [NR*DW-1:0] d;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      if (mask[i] && ((held[i] && ($urandom % 100) >= pd) ||
                      (!held[i] && ($urandom % 100) < pv))) begin
        req_valid[i] = 1'b1;
        d[i*DW +: DW] = tag(i, seq[i]);
      end else begin
        req_valid[i] = 1'b0;
        d[i*DW +: DW] = DW'($urandom);
      end
    end
    req_data  = d;
    fifo_full = (($urandom % 100) < pf);
  endtask

  task automatic one_cycle(input logic [NR-1:0] mask, input int pv, input int pf, input int pd);
    @(posedge clk);
    #1;
    drive(mask, pv, pf, pd);
    #1;
    model_step();
  endtask

  task automatic check_stats();
`ifdef FIFO_WR_ARB_STATS_EN
    @(posedge clk);
    #1;
    drive('0, 0, 0, 0);
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    #1;
    model_step();
`endif
  endtask

  // Monitor: pops per-cycle expectations and the write scoreboard
  always @(negedge clk) begin
    cyc_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("busy", 32'(busy), 32'(e.busy));
      check("req_ready", 32'(req_ready), 32'(e.ready));
      check("w_enable", 32'(w_enable), 32'(|e.ready));
    end
    if (w_enable) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else check("w_data", 32'(w_data), 32'(wr_q.pop_front()));
    end else begin
      check("w_data_idle", 32'(w_data), 32'd0);
    end
  end

  // stimulus table: mask, p_valid%, p_full%, p_drop%, cycles
  localparam int NPH = 5;
  logic [NR-1:0] ph_mask [NPH] = '{4'b0001, 4'b1111, 4'b1111, 4'b1100, 4'b1111};
  int            ph_pv   [NPH] = '{100, 100, 60, 100, 80};
  int            ph_pf   [NPH] = '{0,   0,   25, 0,   60};
  int            ph_pd   [NPH] = '{0,   0,   10, 30,  5};
  int            ph_len  [NPH] = '{30,  40,  300, 60, 200};

  initial begin
    int waited;
    for (int i = 0; i < NR; i++) seq[i] = 0;
    model_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_data  = '0;
    fifo_full = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_w_enable", 32'(w_enable), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b0001, 100, 0, 0);
    #1;
    model_step();

    for (int p = 0; p < NPH; p++) begin
      for (int c = 0; c < ph_len[p]; c++) one_cycle(ph_mask[p], ph_pv[p], ph_pf[p], ph_pd[p]);
      check_stats();
      if (p == 2) begin
        // reset in the middle of a burst
        waited = 0;
        while (!(m_owner >= 0 && m_done >= 2) && waited < 200) begin
          one_cycle(4'b1111, 90, 10, 0);
          waited++;
        end
        check("reset_wait_busy", 32'(waited < 200), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_w_enable", 32'(w_enable), 32'd0);
        check("midrst_w_data", 32'(w_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(4'b1111, 100, 0, 0);
        #1;
        model_step();
        check_stats();
      end
    end

    repeat (3) one_cycle('0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
